// File: rtl/scan_pkg.sv
// Shared types and default widths for the frame scan controller.
package scan_pkg;
  localparam int DEF_COL_BITS  = 10;
  localparam int DEF_ROW_BITS  = 10;
  localparam int DEF_ADDR_BITS = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;
endpackage

// File: rtl/flex_counter.sv
// Generic wrap-around counter: counts 0..rollover_val and back to 0.
// Active-low asynchronous reset; clear has priority over count_enable.
module flex_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);
  logic [NUM_BITS-1:0] r_count;
  logic                w_at_max;

  assign w_at_max = (r_count == rollover_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_count <= '0;
    else if (clear)
      r_count <= '0;
    else if (count_enable)
      r_count <= w_at_max ? '0 : r_count + NUM_BITS'(1);
  end

  assign count_out     = r_count;
  assign rollover_flag = w_at_max;
endmodule

// File: rtl/frame_scan_controller.sv
// Raster-scan sequencer: walks a width x height window issuing one memory
// read per pixel over req/ack, with coordinates and eol/eof markers.
module frame_scan_controller
  import scan_pkg::*;
#(
  parameter int COL_BITS  = DEF_COL_BITS,
  parameter int ROW_BITS  = DEF_ROW_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [COL_BITS-1:0]  img_width,
  input  logic [ROW_BITS-1:0]  img_height,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [COL_BITS-1:0]  col,
  output logic [ROW_BITS-1:0]  row,
  output logic                 eol,
  output logic                 eof,
  output logic                 busy,
  output logic                 done
);
  scan_state_t          r_state;
  logic                 r_rst_n;
  logic                 r_mem_req;
  logic                 r_done;
  logic [COL_BITS-1:0]  r_width;
  logic [ROW_BITS-1:0]  r_height;
  logic [ADDR_BITS-1:0] r_addr;

  logic                 w_start_acc;
  logic                 w_col_en;
  logic                 w_row_en;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_eol;
  logic                 w_eof;
  logic [COL_BITS-1:0]  w_col;
  logic [ROW_BITS-1:0]  w_row;
  logic [COL_BITS-1:0]  w_col_max;
  logic [ROW_BITS-1:0]  w_row_max;

  assign w_start_acc = start & (r_state == IDLE);
  assign w_col_en    = r_mem_req & mem_ack & ~abort;
  assign w_row_en    = w_col_en & w_col_last;
  assign w_col_max   = r_width - COL_BITS'(1);
  assign w_row_max   = r_height - ROW_BITS'(1);

  // Counter reset is async active-low; feed it from a flopped copy of rst.
  always_ff @(posedge clk) begin
    r_rst_n <= ~rst;
  end

  flex_counter #(.NUM_BITS(COL_BITS)) u_col_cnt (
    .clk           (clk),
    .n_rst         (r_rst_n),
    .clear         (w_start_acc),
    .count_enable  (w_col_en),
    .rollover_val  (w_col_max),
    .count_out     (w_col),
    .rollover_flag (w_col_last)
  );

  flex_counter #(.NUM_BITS(ROW_BITS)) u_row_cnt (
    .clk           (clk),
    .n_rst         (r_rst_n),
    .clear         (w_start_acc),
    .count_enable  (w_row_en),
    .rollover_val  (w_row_max),
    .count_out     (w_row),
    .rollover_flag (w_row_last)
  );

  assign w_eol = r_mem_req & w_col_last;
  assign w_eof = w_eol & w_row_last;

  // DONE is entered with r_done already set from SCAN; a zero-size frame
  // enters with it clear and spends one extra cycle before pulsing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mem_req <= 1'b0;
      r_done    <= 1'b0;
      r_width   <= '0;
      r_height  <= '0;
      r_addr    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_width  <= img_width;
            r_height <= img_height;
            r_addr   <= base_addr;
            if (img_width == '0 || img_height == '0) begin
              r_state <= DONE;
            end else begin
              r_state   <= SCAN;
              r_mem_req <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end else if (mem_ack) begin
            r_addr <= r_addr + ADDR_BITS'(1);
            if (w_eof) begin
              r_state   <= DONE;
              r_mem_req <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        DONE: begin
          if (r_done) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_addr;
  assign col      = w_col;
  assign row      = w_row;
  assign eol      = w_eol;
  assign eof      = w_eof;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
endmodule

// File: tb/tb_frame_scan_controller.sv
// Directed plus randomized frames checked against a per-pixel model:
// pixel k of a WxH frame is at (k%W, k/W) with address base+k.
module tb_frame_scan_controller;
  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [9:0]  img_width;
  logic [9:0]  img_height;
  logic [19:0] base_addr;
  logic        mem_ack;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic [9:0]  col;
  logic [9:0]  row;
  logic        eol;
  logic        eof;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  frame_scan_controller dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .img_width  (img_width),
    .img_height (img_height),
    .base_addr  (base_addr),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .col        (col),
    .row        (row),
    .eol        (eol),
    .eof        (eof),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".mem_req"}, 32'(mem_req), 0);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 0);
    chk({tag, ".col"}, 32'(col), 0);
    chk({tag, ".row"}, 32'(row), 0);
    chk({tag, ".eol"}, 32'(eol), 0);
    chk({tag, ".eof"}, 32'(eof), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
  endtask

  // mode: 0 = ack every cycle, 1 = random ack, 2 = ack after 2 wait cycles.
  // abort_k / start_k / rst_k: pixel index for that event, -1 for none.
  task automatic run_frame(input int w, input int h, input logic [19:0] base,
                           input int mode, input int abort_k, input int start_k,
                           input int rst_k);
    int          total;
    int          k;
    int          cyc;
    logic        ack;
    logic [19:0] exp_addr;
    total = w * h;
    start      = 1'b1;
    img_width  = 10'(w);
    img_height = 10'(h);
    base_addr  = base;
    mem_ack    = (mode == 0);
    @(negedge clk);
    start      = 1'b0;
    img_width  = 10'($urandom);
    img_height = 10'($urandom);
    base_addr  = 20'($urandom);

    if (total == 0) begin
      chk("zero.n1.mem_req", 32'(mem_req), 0);
      chk("zero.n1.busy", 32'(busy), 1);
      chk("zero.n1.done", 32'(done), 0);
      chk("zero.n1.col", 32'(col), 0);
      chk("zero.n1.row", 32'(row), 0);
      @(negedge clk);
      chk("zero.n2.mem_req", 32'(mem_req), 0);
    end else begin
      k = 0;
      cyc = 0;
      while (k < total) begin
        exp_addr = base + 20'(k);
        chk("px.mem_req", 32'(mem_req), 1);
        chk("px.mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("px.col", 32'(col), 32'(k % w));
        chk("px.row", 32'(row), 32'(k / w));
        chk("px.eol", 32'(eol), 32'((k % w) == w - 1));
        chk("px.eof", 32'(eof), 32'(k == total - 1));
        chk("px.busy", 32'(busy), 1);
        chk("px.done", 32'(done), 0);

        if (k == rst_k) begin
          rst = 1'b1;
          mem_ack = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          mem_ack = 1'b0;
          chk_reset_vals("midrst");
          @(negedge clk);
          chk("midrst.no_done", 32'(done), 0);
          chk("midrst.busy", 32'(busy), 0);
          return;
        end

        case (mode)
          0:       ack = 1'b1;
          2:       ack = (cyc == 2);
          default: ack = 1'($urandom_range(1));
        endcase
        mem_ack = ack;
        if (k == abort_k && ack) abort = 1'b1;
        if (k == start_k && cyc == 0) begin
          start      = 1'b1;
          img_width  = 10'd2;
          img_height = 10'd2;
          base_addr  = 20'h00000;
        end
        @(negedge clk);
        start = 1'b0;
        if (abort) begin
          abort = 1'b0;
          mem_ack = 1'b0;
          chk("abort.mem_req", 32'(mem_req), 0);
          chk("abort.busy", 32'(busy), 0);
          chk("abort.done", 32'(done), 0);
          @(negedge clk);
          chk("abort.no_done", 32'(done), 0);
          return;
        end
        if (ack) begin
          k++;
          cyc = 0;
        end else begin
          cyc++;
        end
      end
    end

    chk("fin.done", 32'(done), 1);
    chk("fin.busy", 32'(busy), 1);
    chk("fin.mem_req", 32'(mem_req), 0);
    start      = 1'b1;
    img_width  = 10'd2;
    img_height = 10'd2;
    mem_ack    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("post.done", 32'(done), 0);
    chk("post.busy", 32'(busy), 0);
    chk("post.mem_req", 32'(mem_req), 0);
  endtask

  initial begin
    logic [19:0] rb;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    img_width  = '0;
    img_height = '0;
    base_addr  = '0;
    mem_ack    = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle");

    run_frame(4, 2, 20'h00100, 0, -1, -1, -1);
    run_frame(3, 1, 20'h00000, 2, -1, -1, -1);
    run_frame(0, 5, 20'h00123, 0, -1, -1, -1);
    run_frame(4, 0, 20'h00456, 0, -1, -1, -1);
    run_frame(4, 4, 20'h00200, 0, 5, -1, -1);
    run_frame(4, 4, 20'h00200, 1, -1, -1, -1);
    run_frame(4, 1, 20'hFFFFE, 0, -1, 2, -1);
    run_frame(4, 3, 20'h00050, 0, -1, -1, 5);
    run_frame(4, 3, 20'h00050, 1, -1, -1, -1);
    run_frame(1, 1, 20'hFFFFF, 0, -1, -1, -1);
    for (int i = 0; i < 8; i++) begin
      rb = 20'($urandom);
      run_frame(int'($urandom_range(6, 1)), int'($urandom_range(4, 1)), rb,
                int'($urandom_range(2, 0)), -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
